// File: rtl/rf_wb_arb_pkg.sv
// Shared widths and starvation-FSM state encoding for the register-file write-port arbiter.
package rf_wb_arb_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rf_wb_arb_scoreboard.sv
// Busy-register scoreboard: one flop per register of outstanding long-latency destinations,
// plus the three-port decode hazard lookup. RF_WB_ARB_EARLY_CLEAR_EN unmasks committing registers.
module rf_scoreboard
  import rf_wb_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set_valid_i,
  input  logic [AW-1:0]   set_idx_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_idx_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  output logic            hazard_o,
  output logic [NREG-1:0] busy_o
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] look;
  logic            set_en;

  assign set_en = set_valid_i && (set_idx_i != '0);

  // Clear first, then set, so a same-cycle set of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en)   busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    look = busy_q;
`ifdef RF_WB_ARB_EARLY_CLEAR_EN
    if (clr_en_i && !(set_en && (set_idx_i == clr_idx_i))) look[clr_idx_i] = 1'b0;
`endif
    hazard_o = look[rs1_i] | look[rs2_i] | look[rd_i];
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, a starvation FSM forces a WB
// bubble for the long-latency unit. Optional macro RF_WB_ARB_EARLY_CLEAR_EN (see scoreboard).
module rf_wb_arbiter
  import rf_wb_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_we,
  input  logic [AW-1:0]   pipe_rd,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            ext_issue,
  input  logic [AW-1:0]   ext_issue_rd,
  input  logic            ext_valid,
  input  logic [AW-1:0]   ext_rd,
  input  logic [XLEN-1:0] ext_wdata,
  output logic            ext_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  output logic            hazard_stall,
  output logic            force_stall,
  output logic            rf_write_en,
  output logic [AW-1:0]   rf_write_addr,
  output logic [XLEN-1:0] rf_write_value,
  output logic [NREG-1:0] busy_vec,
  output logic [1:0]      dbg_state_o
);
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  // Handshake: ext result is accepted exactly when ext_valid && ext_ready in the same cycle.
  arb_state_t    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d, cnt_inc;
  logic          handshake;

  assign ext_ready = !reset && !pipe_we;
  assign handshake = ext_valid && ext_ready;

  always_comb begin
    rf_write_en    = 1'b0;
    rf_write_addr  = '0;
    rf_write_value = '0;
    if (!reset) begin
      if (pipe_we) begin
        rf_write_en    = 1'b1;
        rf_write_addr  = pipe_rd;
        rf_write_value = pipe_wdata;
      end else if (ext_valid) begin
        rf_write_en    = 1'b1;
        rf_write_addr  = ext_rd;
        rf_write_value = ext_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cnt_inc    = wait_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (ext_valid && !ext_ready) begin
          wait_cnt_d = CW'(1);
          state_d    = (CW'(1) >= LIMIT) ? ST_FORCE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (handshake || !ext_valid) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = cnt_inc;
          if (cnt_inc >= LIMIT) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        // Pipe keeps the port if it ignores force_stall; otherwise ext got this slot.
        if (!pipe_we) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_stall = (state_q == ST_FORCE);
  assign dbg_state_o = state_q;

  a_force_gates_pipe: assert property (@(posedge clk) disable iff (reset) force_stall |-> !pipe_we);

  rf_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .set_valid_i (ext_issue),
    .set_idx_i   (ext_issue_rd),
    .clr_en_i    (handshake),
    .clr_idx_i   (ext_rd),
    .rs1_i       (rs1_addr),
    .rs2_i       (rs2_addr),
    .rd_i        (rd_addr),
    .hazard_o    (hazard_stall),
    .busy_o      (busy_vec)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;
  import rf_wb_arb_pkg::*;

  localparam int MAX_WAIT = 4;
`ifdef RF_WB_ARB_EARLY_CLEAR_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk, reset;
  logic            pipe_we, ext_issue, ext_valid;
  logic [AW-1:0]   pipe_rd, ext_issue_rd, ext_rd, rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0] pipe_wdata, ext_wdata;
  logic            ext_ready, hazard_stall, force_stall, rf_write_en;
  logic [AW-1:0]   rf_write_addr;
  logic [XLEN-1:0] rf_write_value;
  logic [NREG-1:0] busy_vec;
  logic [1:0]      dbg_state;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .ext_issue(ext_issue), .ext_issue_rd(ext_issue_rd),
    .ext_valid(ext_valid), .ext_rd(ext_rd), .ext_wdata(ext_wdata), .ext_ready(ext_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .hazard_stall(hazard_stall), .force_stall(force_stall),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_value(rf_write_value),
    .busy_vec(busy_vec), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: set of busy registers and how long the current ext result has waited.
  bit m_busy[NREG];
  int m_waited = 0;
  logic m_hs;

  function automatic bit m_force();
    return m_waited >= MAX_WAIT - 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_waited = 0;
    end else begin
      m_hs = ext_valid && !pipe_we;
      if (m_hs) m_busy[ext_rd] = 1'b0;
      if (ext_issue && ext_issue_rd != '0) m_busy[ext_issue_rd] = 1'b1;
      if (ext_valid && !m_hs) m_waited = m_waited + 1;
      else m_waited = 0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  logic [NREG-1:0] exp_busy, eff_busy;
  logic            exp_en, exp_haz, exp_force;
  logic [1:0]      exp_state;

  always @(negedge clk) begin
    if (chk_en) begin
      foreach (m_busy[i]) exp_busy[i] = m_busy[i];
      if (reset) begin
        chk("rst_en", rf_write_en, 1'b0);
        chk("rst_ready", ext_ready, 1'b0);
        chk("rst_busy", busy_vec, '0);
        chk("rst_force", force_stall, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
      end else begin
        eff_busy = exp_busy;
        if (EARLY && ext_valid && !pipe_we &&
            !(ext_issue && ext_issue_rd == ext_rd && ext_rd != '0))
          eff_busy[ext_rd] = 1'b0;
        exp_haz   = eff_busy[rs1_addr] | eff_busy[rs2_addr] | eff_busy[rd_addr];
        exp_en    = pipe_we || ext_valid;
        exp_force = m_force();
        exp_state = (m_waited == 0) ? 2'd0 : (exp_force ? 2'd2 : 2'd1);
        chk("ext_ready", ext_ready, !pipe_we);
        chk("wr_en", rf_write_en, exp_en);
        if (exp_en) begin
          chk("wr_addr", rf_write_addr, pipe_we ? pipe_rd : ext_rd);
          chk("wr_value", rf_write_value, pipe_we ? pipe_wdata : ext_wdata);
        end
        chk("busy_vec", busy_vec, exp_busy);
        chk("hazard", hazard_stall, exp_haz);
        chk("force", force_stall, exp_force);
        chk("state", dbg_state, exp_state);
      end
    end
  end

  // Driver helpers: inputs change 2 time units after the active edge.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; ext_issue = 1'b0; ext_valid = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
  endtask

  logic [AW-1:0] pend_q[$];
  int            rst_hold;
  logic          last_hs;

  function automatic logic [AW-1:0] pick_reg();
    if (pend_q.size() > 0 && $urandom_range(0, 1) == 0)
      return pend_q[$urandom_range(0, pend_q.size() - 1)];
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    reset = 1'b1;
    pipe_rd = '0; pipe_wdata = '0; ext_issue_rd = '0; ext_rd = '0; ext_wdata = '0;
    idle_inputs();
    pipe_we = 1'b1; pipe_rd = AW'(5); pipe_wdata = 32'h1234;
    chk_en = 1'b1;

    // Reset held with pipe_we=1: no write, clean state.
    #6;
    chk("lit_rst_en", rf_write_en, 1'b0);
    chk("lit_rst_busy", busy_vec, '0);
    chk("lit_rst_force", force_stall, 1'b0);
    next(); next();
    reset = 1'b0;
    #4;
    chk("lit_rel_en", rf_write_en, 1'b1);
    chk("lit_rel_addr", rf_write_addr, 5);
    chk("lit_rel_val", rf_write_value, 32'h1234);

    // Contention: pipe wins, then ext commits rd=7.
    next(); idle_inputs(); ext_issue = 1'b1; ext_issue_rd = AW'(7);
    next(); ext_issue = 1'b0;
    pipe_we = 1'b1; pipe_rd = AW'(3); pipe_wdata = 32'h33;
    ext_valid = 1'b1; ext_rd = AW'(7); ext_wdata = 32'hAA;
    #4;
    chk("lit_cont_addr", rf_write_addr, 3);
    chk("lit_cont_ready", ext_ready, 1'b0);
    chk("lit_cont_busy7", busy_vec[7], 1'b1);
    next(); pipe_we = 1'b0;
    #4;
    chk("lit_ext_addr", rf_write_addr, 7);
    chk("lit_ext_val", rf_write_value, 32'hAA);
    chk("lit_ext_ready", ext_ready, 1'b1);
    next(); ext_valid = 1'b0;
    #4;
    chk("lit_clr_busy7", busy_vec[7], 1'b0);
    chk("lit_cont_idle", dbg_state, 2'd0);

    // Starvation: forced slot in cycle 3, back to idle in cycle 4.
    next(); pipe_we = 1'b1; pipe_rd = AW'(4); pipe_wdata = 32'h44;
    ext_valid = 1'b1; ext_rd = AW'(9); ext_wdata = 32'h99;
    for (int c = 0; c < 3; c++) begin
      #4; chk("lit_starve_nf", force_stall, 1'b0);
      next();
    end
    pipe_we = 1'b0;
    #4;
    chk("lit_starve_force", force_stall, 1'b1);
    chk("lit_starve_addr", rf_write_addr, 9);
    next(); ext_valid = 1'b0;
    #4;
    chk("lit_starve_idle", dbg_state, 2'd0);
    chk("lit_starve_nf2", force_stall, 1'b0);

    // Scoreboard hazard on rd=10.
    next(); ext_issue = 1'b1; ext_issue_rd = AW'(10);
    next(); ext_issue = 1'b0; rs2_addr = AW'(10);
    #4; chk("lit_haz_rs2", hazard_stall, 1'b1);
    next(); rs2_addr = '0;
    #4; chk("lit_haz_zero", hazard_stall, 1'b0);
    next(); ext_valid = 1'b1; ext_rd = AW'(10); ext_wdata = 32'h10; rs2_addr = AW'(10);
    #4; chk("lit_haz_commit10", hazard_stall, !EARLY);
    next(); ext_valid = 1'b0;
    #4; chk("lit_haz_after10", hazard_stall, 1'b0);
    rs2_addr = '0;

    // Same-cycle set/clear of rd=12, then early-clear on rs1=12.
    next(); ext_issue = 1'b1; ext_issue_rd = AW'(12);
    next(); ext_valid = 1'b1; ext_rd = AW'(12); ext_wdata = 32'h12;
    next(); ext_issue = 1'b0; ext_wdata = 32'h121; rs1_addr = AW'(12);
    #4;
    chk("lit_setwins12", busy_vec[12], 1'b1);
    chk("lit_early12", hazard_stall, !EARLY);
    next(); ext_valid = 1'b0;
    #4;
    chk("lit_clr12", busy_vec[12], 1'b0);
    chk("lit_haz12_done", hazard_stall, 1'b0);

    // Randomized traffic.
    idle_inputs();
    rst_hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next();
      last_hs = ext_valid && !pipe_we && !reset;
      if (last_hs) begin
        void'(pend_q.pop_front());
        ext_valid = 1'b0;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; rst_hold = 2;
        pend_q.delete();
        ext_valid = 1'b0;
      end
      if (ext_valid && $urandom_range(0, 149) == 0) ext_valid = 1'b0;
      if (!ext_valid && !reset && pend_q.size() > 0 && $urandom_range(0, 1) == 0) begin
        ext_valid = 1'b1; ext_rd = pend_q[0]; ext_wdata = $urandom;
      end
      ext_issue = ($urandom_range(0, 3) == 0) && !reset;
      ext_issue_rd = AW'($urandom_range(0, NREG - 1));
      if (ext_issue && ext_issue_rd != '0 && pend_q.size() < 8) pend_q.push_back(ext_issue_rd);
      else ext_issue = 1'b0;
      pipe_we = ($urandom_range(0, 9) < 7) && !m_force();
      pipe_rd = AW'($urandom_range(0, NREG - 1));
      pipe_wdata = $urandom;
      rs1_addr = pick_reg(); rs2_addr = pick_reg(); rd_addr = pick_reg();
    end

    next();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the register file and shares it between the in-order pipeline write-back stage and one long-latency unit (mul/div or load miss).
- Pipeline WB has priority. A starvation FSM forces a WB bubble when the long-latency unit has waited too long.
- A busy-register scoreboard tracks outstanding long-latency destinations and raises a decode-stage hazard stall.

Parameters:
XLEN, 32, data width
NREG, 32, register count
AW, 5, register address width
MAX_WAIT, 4, max cycles ext may wait before a forced slot (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pipe_we  in  1  pipeline WB write request (no backpressure)
pipe_rd  in  AW  pipeline WB destination
pipe_wdata  in  XLEN  pipeline WB data
ext_issue  in  1  long-latency op issued this cycle
ext_issue_rd  in  AW  its destination
ext_valid  in  1  long-latency result valid
ext_rd  in  AW  result destination
ext_wdata  in  XLEN  result data
ext_ready  out  1  result accepted this cycle
rs1_addr, rs2_addr, rd_addr  in  AW each  decode-stage operands/dest
hazard_stall  out  1  decode must stall
force_stall  out  1  pipeline must hold pipe_we=0 this cycle
rf_write_en  out  1  to register file
rf_write_addr  out  AW  to register file
rf_write_value  out  XLEN  to register file
busy_vec  out  NREG  scoreboard state, for debug/verification

Behaviour:
- Reset (async, active-high): busy_vec=0, FSM=IDLE, wait_cnt=0, force_stall=0. While reset is high: rf_write_en=0, ext_ready=0.
- Grant (combinational, zero latency):
  - ext_ready = !pipe_we.
  - pipe_we=1: rf_write_* = pipe fields.
  - else ext_valid=1: rf_write_* = ext fields; handshake occurs when ext_valid && ext_ready.
  - else rf_write_en=0.
- rd=0 writes pass through unchanged; the register file discards them. Ext handshakes with rd=0 complete normally.
- ext protocol: once ext_valid=1, ext_rd/ext_wdata stay stable until handshake.
- FSM (state and counter registered; force_stall = (state==FORCE), a flop output):
  - IDLE: ext_valid && !ext_ready -> WAIT, wait_cnt=1. Otherwise stay.
  - WAIT:
    - handshake -> IDLE, wait_cnt=0.
    - ext_valid drops (protocol violation) -> IDLE.
    - otherwise wait_cnt++; on reaching MAX_WAIT-1 -> FORCE.
  - FORCE: the pipeline gates pipe_we with !force_stall in the same cycle, so ext is granted and the FSM moves -> IDLE. If pipe_we=1 anyway, pipe still wins, the FSM stays in FORCE, and a simulation assertion fires.
  - Worst-case ext wait: MAX_WAIT cycles from first assertion.
- Scoreboard (NREG flops, bit 0 hardwired 0):
  - set busy[ext_issue_rd] on ext_issue when rd!=0.
  - clear busy[ext_rd] on ext handshake.
  - simultaneous set and clear of the same index: set wins.
  - issue to an already-busy rd: bit stays set. Decode prevents this via the rd_addr check.
- hazard_stall = busy[rs1_addr] | busy[rs2_addr] | busy[rd_addr], combinational from registered busy_vec. Index 0 never stalls.
- Reset mid-operation: busy bits lost and FSM returns to IDLE. The ext unit must be reset by the same reset.

Optional Feature:
- Macro: RF_WB_ARB_EARLY_CLEAR_EN.
- Defined: hazard_stall masks any index being cleared by an ext handshake this cycle (set-wins still applies). A consumer stalled on a result proceeds in the commit cycle and reads the value through the register file's same-cycle write/read path.
- Undefined: hazard_stall uses registered busy_vec only, so the consumer stalls one extra cycle after commit.

Decomposition:
- Shared package/header rf_wb_arb_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1, FORCE=2'd2), XLEN, AW, NREG.
- One natural sub-module, rf_scoreboard: busy_vec flops, set/clear logic, 3-port hazard lookup and the early-clear mask.
- The arbiter top holds the grant mux and the starvation FSM.

Test Plan:
- Reset: hold reset 3 cycles with pipe_we=1 -> rf_write_en=0, busy_vec=0, force_stall=0. Release -> pipe write to x5=0x1234 appears the same cycle.
- Contention: pipe_we=1 (rd=3) and ext_valid=1 (rd=7, 0xAA) together -> rf_write_addr=3, ext_ready=0. Drop pipe_we -> rd=7 written, handshake, busy[7] cleared.
- Starvation, MAX_WAIT=4: pipe_we held high, ext_valid=1 -> force_stall rises in cycle 3. Bench drops pipe_we -> ext written in cycle 3, FSM back to IDLE in cycle 4.
- Scoreboard: ext_issue rd=10, then decode rs2=10 -> hazard_stall=1 until ext commits rd=10. rs1=0 with busy_vec=0 -> never stalls.
- Same-cycle set/clear: ext_issue rd=12 while the ext handshake commits rd=12 -> busy[12]=1 afterwards.
- Early clear: with the macro defined, stall on rs1=12 deasserts in the commit cycle. Without it, it deasserts one cycle later.
